hilo_div_ctrl: RTL

// - EX-stage sequencer upstream of the 32-bit iterative divider; owns HI/LO.
// - Latches DIV/DIVU operands, issues one divider request, stalls EX until done,

---
 rtl/hilo_div_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: EX-stage sequencer for the iterative divider; owns HI/LO and runs DIV/DIVU/MTHI/MTLO.
// Latency: DIV in EX at T -> div_req at T+1, HI/LO written on div_complete, retires from EX in DONE.
// Backpressure: ex_stall holds IF..EX for the whole launch/wait window. A new DIV is held in EX while a killed divide drains.
//
// Build option: define HILO_DIV0_BYPASS_EN to resolve a zero divisor locally.
// In that case the divider is skipped, lo = all ones, hi = dividend, and EX stalls for only one cycle.
//
// Ports:
//   clk, reset                     clock; synchronous active-high reset
//                                  (the enclosing top drives divider resetn = ~reset)
//   ex_valid, ex_div, ex_divu,     instruction in EX and its decode
//   ex_mthi, ex_mtlo
//   ex_flush                       later stage kills the EX instruction
//   ex_src_a, ex_src_b             rs / rt operand values
//   ex_stall                       hold IF..EX this cycle
//   hi, lo                         architectural HI/LO
//   div_err                        sticky: divider did not answer within TIMEOUT_CYC
//   div_req, div_signed,           request, signedness and operands to the divider
//   div_x, div_y
//   div_s, div_r, div_complete     quotient, remainder and one-cycle valid from the divider
module hilo_div_ctrl #(
  parameter int TIMEOUT_CYC = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_div,
  input  logic        ex_divu,
  input  logic        ex_mthi,
  input  logic        ex_mtlo,
  input  logic        ex_flush,
  input  logic [31:0] ex_src_a,
  input  logic [31:0] ex_src_b,
  output logic        ex_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_err,
  output logic        div_req,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          start;
  logic          div0;

  assign start = ex_valid & (ex_div | ex_divu) & ~ex_flush;

`ifdef HILO_DIV0_BYPASS_EN
  assign div0 = (ex_src_b == 32'd0);
`else
  assign div0 = 1'b0;
`endif

  // In DRAIN the killed instruction has already left EX. A new DIV must still
  // wait, because the divider is busy with the discarded operation.
  always_comb begin
    ex_stall = 1'b0;
    case (state)
      S_IDLE, S_DRAIN:  ex_stall = start;
      S_LAUNCH, S_WAIT: ex_stall = 1'b1;
      default:          ex_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      hi         <= 32'd0;
      lo         <= 32'd0;
      div_req    <= 1'b0;
      div_signed <= 1'b0;
      div_x      <= 32'd0;
      div_y      <= 32'd0;
      div_err    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      div_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (div0) begin
              lo    <= 32'hFFFF_FFFF;
              hi    <= ex_src_a;
              state <= S_DONE;
            end else begin
              div_x      <= ex_src_a;
              div_y      <= ex_src_b;
              div_signed <= ex_div;
              div_req    <= 1'b1;     // high for exactly the LAUNCH cycle
              state      <= S_LAUNCH;
            end
          end else if (ex_valid && !ex_flush) begin
            if (ex_mthi) hi <= ex_src_a;
            if (ex_mtlo) lo <= ex_src_a;
          end
        end
        S_LAUNCH: begin
          // The request has already gone out and the divider cannot abort,
          // so a flush here still has to wait for the result and drop it.
          wait_cnt <= '0;
          state    <= ex_flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          // After a timeout the block stays frozen until reset.
          if (!div_err) begin
            if (ex_flush) begin
              // If the result lands in the same cycle as the kill, nothing is
              // left in flight, so return straight to IDLE without writing.
              state <= div_complete ? S_IDLE : S_DRAIN;
            end else if (div_complete) begin
              hi    <= div_r;
              lo    <= div_s;
              state <= S_DONE;
            end else if (wait_cnt == TO_VAL) begin
              div_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (div_complete) state <= S_IDLE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
